// File: rtl/read_buffered.sv
// read_buffered: operand-read stage feeding a DEPTH-entry output FIFO, with memory fetch FSM and stall counter
// Ports: clock/reset_n (async active-low); registers (flattened file); in_* decode bundle with in_hold back-pressure;
//   address_enable/address/data_valid/data memory read port; out_* FIFO head with out_hold back-pressure;
//   stall_count saturating memory-wait counter.
// Optional READ_BYPASS_EN adds wb_enable/wb_register/wb_value forwarding into operand and address reads.
module read_buffered #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT = 16,
  parameter int PC_INDEX = 15,
  parameter int DEPTH = 2,
  parameter int PAYLOAD_WIDTH = 8,
  localparam int RW = $clog2(REG_COUNT)
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [REG_COUNT*DATA_WIDTH-1:0] registers,
  input  logic                            in_valid,
  output logic                            in_hold,
  input  logic [DATA_WIDTH-1:0]           in_pc,
  input  logic [RW-1:0]                   in_left_reg,
  input  logic [RW-1:0]                   in_right_reg,
  input  logic                            in_right_is_memory,
  input  logic [DATA_WIDTH-1:0]           in_adjustment,
  input  logic [PAYLOAD_WIDTH-1:0]        in_payload,
  input  logic                            in_has_flushed,
  output logic                            address_enable,
  output logic [DATA_WIDTH-1:0]           address,
  input  logic                            data_valid,
  input  logic [DATA_WIDTH-1:0]           data,
  output logic                            out_valid,
  input  logic                            out_hold,
  output logic [DATA_WIDTH-1:0]           out_pc,
  output logic [DATA_WIDTH-1:0]           out_left_value,
  output logic [DATA_WIDTH-1:0]           out_right_value,
  output logic [DATA_WIDTH-1:0]           out_adjustment,
  output logic [PAYLOAD_WIDTH-1:0]        out_payload,
  output logic                            out_has_flushed,
`ifdef READ_BYPASS_EN
  input  logic                            wb_enable,
  input  logic [RW-1:0]                   wb_register,
  input  logic [DATA_WIDTH-1:0]           wb_value,
`endif
  output logic [15:0]                     stall_count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int EW = 4 * DATA_WIDTH + PAYLOAD_WIDTH + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;
  function automatic logic [DATA_WIDTH-1:0] rd(input logic [RW-1:0] i);
    logic [DATA_WIDTH-1:0] v;
    v = registers[int'(i)*DATA_WIDTH +: DATA_WIDTH];
`ifdef READ_BYPASS_EN
    if (wb_enable && i == wb_register) v = wb_value;
`endif
    return i == RW'(PC_INDEX) ? in_pc : v;
  endfunction
  logic [EW-1:0] fifo [DEPTH];
  logic [CW-1:0] count;
  logic [PW-1:0] rd_ptr, wr_ptr;
  logic [0:0] state;
  logic last_flush, head_flush, full, pop, space, push, wait_cycle;
  logic [DATA_WIDTH-1:0] right_value;
  assign full = count == CW'(DEPTH);
  assign out_valid = count != '0;
  assign pop = out_valid && !out_hold;
  assign space = !full || pop;
  assign address_enable = reset_n && in_valid && in_right_is_memory && space;
  assign push = in_valid && space && (!in_right_is_memory || data_valid);
  assign in_hold = reset_n && in_valid && !push;
  assign address = rd(in_right_reg) + in_adjustment;
  assign right_value = in_right_is_memory ? data : rd(in_right_reg);
  assign wait_cycle = address_enable && !data_valid;
  assign {out_pc, out_left_value, out_right_value, out_adjustment, out_payload, head_flush} = fifo[rd_ptr];
  // With the FIFO empty the flush marker follows decode one cycle late.
  assign out_has_flushed = out_valid ? head_flush : last_flush;
  always_ff @(posedge clock)
    if (push) fifo[wr_ptr] <= {in_pc, rd(in_left_reg), right_value, in_adjustment, in_payload, in_has_flushed};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      count <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      last_flush <= 1'b0;
      state <= IDLE;
      stall_count <= '0;
    end else begin
      count <= count + CW'(push) - CW'(pop);
      if (push) wr_ptr <= wr_ptr == PW'(DEPTH - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH - 1) ? '0 : rd_ptr + 1'b1;
      last_flush <= in_has_flushed;
      state <= state == IDLE ? (wait_cycle ? ST_WAIT : IDLE) : (data_valid || !address_enable ? IDLE : ST_WAIT);
      if (wait_cycle && stall_count != '1) stall_count <= stall_count + 1'b1;
    end
endmodule

// File: tb/tb_read_buffered.sv
// tb_read_buffered: scoreboard bench for read_buffered with directed operand, memory, back-pressure and reset vectors
module tb_read_buffered;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] left;
    logic [31:0] right;
    logic [31:0] adj;
    logic [7:0]  pay;
    logic        fl;
  } ent_t;
  logic clock = 0, reset_n = 0;
  logic [16*32-1:0] registers = '0;
  logic in_valid = 0, in_hold, in_right_is_memory = 0, in_has_flushed = 0;
  logic [31:0] in_pc = 0, in_adjustment = 0, address, data = 0;
  logic [3:0] in_left_reg = 0, in_right_reg = 0;
  logic [7:0] in_payload = 0, out_payload;
  logic address_enable, data_valid = 0, out_valid, out_hold = 0, out_has_flushed;
  logic [31:0] out_pc, out_left_value, out_right_value, out_adjustment;
  logic [15:0] stall_count;
`ifdef READ_BYPASS_EN
  logic wb_enable = 0;
  logic [3:0] wb_register = 0;
  logic [31:0] wb_value = 0;
`endif
  int checks = 0, errors = 0, pops = 0;
  ent_t q[$];
  read_buffered dut (
    .clock(clock), .reset_n(reset_n), .registers(registers),
    .in_valid(in_valid), .in_hold(in_hold), .in_pc(in_pc),
    .in_left_reg(in_left_reg), .in_right_reg(in_right_reg),
    .in_right_is_memory(in_right_is_memory), .in_adjustment(in_adjustment),
    .in_payload(in_payload), .in_has_flushed(in_has_flushed),
    .address_enable(address_enable), .address(address),
    .data_valid(data_valid), .data(data),
    .out_valid(out_valid), .out_hold(out_hold), .out_pc(out_pc),
    .out_left_value(out_left_value), .out_right_value(out_right_value),
    .out_adjustment(out_adjustment), .out_payload(out_payload),
    .out_has_flushed(out_has_flushed),
`ifdef READ_BYPASS_EN
    .wb_enable(wb_enable), .wb_register(wb_register), .wb_value(wb_value),
`endif
    .stall_count(stall_count)
  );
  always #5 clock = ~clock;
  always @(negedge clock)
    if (reset_n && out_valid && !out_hold) begin
      ent_t e, a;
      checks++;
      pops++;
      a = '{out_pc, out_left_value, out_right_value, out_adjustment, out_payload, out_has_flushed};
      if (q.size() == 0) begin
        errors++;
        $display("FAIL head_unexpected got %h with nothing expected", a);
      end else begin
        e = q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL head got pc=%h l=%h r=%h adj=%h pay=%h fl=%b want pc=%h l=%h r=%h adj=%h pay=%h fl=%b",
                   a.pc, a.left, a.right, a.adj, a.pay, a.fl, e.pc, e.left, e.right, e.adj, e.pay, e.fl);
        end
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", name, act, exp);
    end
  endtask
  task automatic setreg(input int i, input logic [31:0] v);
    registers[i*32 +: 32] = v;
  endtask
  task automatic alu(input logic [3:0] l, input logic [3:0] r, input logic [31:0] pc, input logic [31:0] adj,
                     input logic [7:0] pay, input logic fl, input logic [31:0] el, input logic [31:0] er);
    int n;
    in_valid = 1; in_right_is_memory = 0; in_left_reg = l; in_right_reg = r;
    in_pc = pc; in_adjustment = adj; in_payload = pay; in_has_flushed = fl;
    n = 0;
    @(negedge clock);
    while (in_hold && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk("alu_accept", {31'b0, in_hold}, 0);
    if (!in_hold) q.push_back('{pc, el, er, adj, pay, fl});
    @(posedge clock); #1;
    in_valid = 0;
  endtask
  task automatic mem(input logic [3:0] l, input logic [3:0] r, input logic [31:0] pc, input logic [31:0] adj,
                     input logic [31:0] el, input logic [31:0] ea, input int waits, input logic [31:0] d);
    in_valid = 1; in_right_is_memory = 1; in_left_reg = l; in_right_reg = r;
    in_pc = pc; in_adjustment = adj; in_payload = 8'h5A; in_has_flushed = 0; data_valid = 0;
    for (int i = 0; i < waits; i++) begin
      @(negedge clock);
      chk("mem_wait_address", address, ea);
      chk("mem_wait_enable", {31'b0, address_enable}, 1);
      chk("mem_wait_hold", {31'b0, in_hold}, 1);
      @(posedge clock); #1;
    end
    data_valid = 1; data = d;
    @(negedge clock);
    chk("mem_done_address", address, ea);
    chk("mem_done_hold", {31'b0, in_hold}, 0);
    if (!in_hold) q.push_back('{pc, el, d, adj, 8'h5A, 1'b0});
    @(posedge clock); #1;
    in_valid = 0; data_valid = 0; in_right_is_memory = 0;
  endtask
  task automatic drain;
    int n;
    n = 0;
    while ((q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    chk("drain_empty", q.size(), 0);
  endtask
  initial begin
    int p0;
    setreg(1, 5); setreg(2, 7); setreg(3, 32'h100); setreg(4, 32'hFFFF_FFFE);
    in_valid = 1; in_right_is_memory = 1;
    #1;
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_addr_en", {31'b0, address_enable}, 0);
    chk("rst_in_hold", {31'b0, in_hold}, 0);
    chk("rst_stall", {16'b0, stall_count}, 0);
    chk("rst_flush", {31'b0, out_has_flushed}, 0);
    in_valid = 0; in_right_is_memory = 0;
    @(posedge clock); #1;
    reset_n = 1;
    @(posedge clock); #1;
    alu(1, 2, 32'h10, 32'h3, 8'h11, 0, 5, 7);
    @(negedge clock);
    chk("t1_latency_valid", {31'b0, out_valid}, 1);
    @(posedge clock); #1;
    mem(1, 3, 32'h20, 32'h4, 5, 32'h104, 3, 32'hAB);
    @(negedge clock);
    chk("t2_stall", {16'b0, stall_count}, 3);
    chk("t2_addr_en_idle", {31'b0, address_enable}, 0);
    @(posedge clock); #1;
    mem(2, 4, 32'h24, 32'h5, 7, 32'h3, 0, 32'hCD);
    chk("wrap_stall", {16'b0, stall_count}, 3);
    drain();
    out_hold = 1;
    alu(2, 1, 32'h30, 32'h0, 8'h21, 0, 7, 5);
    mem(1, 3, 32'h34, 32'h8, 5, 32'h108, 2, 32'h77);
    in_valid = 1; in_right_is_memory = 1; in_right_reg = 3;
    @(negedge clock);
    chk("t4_full_addr_en", {31'b0, address_enable}, 0);
    chk("t4_full_hold", {31'b0, in_hold}, 1);
    @(posedge clock); #1;
    chk("t4_stall", {16'b0, stall_count}, 5);
    in_valid = 0; in_right_is_memory = 0; out_hold = 0;
    drain();
    out_hold = 1;
    alu(1, 1, 32'h50, 32'h1, 8'hA1, 0, 5, 5);
    alu(2, 2, 32'h54, 32'h2, 8'hA2, 0, 7, 7);
    in_valid = 1; in_left_reg = 3; in_right_reg = 1; in_pc = 32'h58; in_adjustment = 3; in_payload = 8'hA3;
    @(negedge clock);
    chk("t3_third_held", {31'b0, in_hold}, 1);
    @(posedge clock); #1;
    p0 = pops;
    out_hold = 0;
    @(negedge clock);
    chk("t3_third_accept", {31'b0, in_hold}, 0);
    if (!in_hold) q.push_back('{32'h58, 32'h100, 32'h5, 32'h3, 8'hA3, 1'b0});
    @(posedge clock); #1;
    in_valid = 0;
    @(negedge clock);
    @(negedge clock); #1;
    chk("t3_one_per_cycle", pops - p0, 3);
    drain();
    alu(15, 1, 32'h40, 32'h0, 8'h05, 0, 32'h40, 5);
`ifdef READ_BYPASS_EN
    wb_enable = 1; wb_register = 1; wb_value = 9;
    alu(1, 2, 32'h44, 32'h0, 8'h06, 0, 9, 7);
    wb_enable = 0;
`endif
    in_has_flushed = 1;
    @(posedge clock); #1;
    chk("flush_empty_track", {31'b0, out_has_flushed}, 1);
    alu(2, 2, 32'h48, 32'h0, 8'h07, 1, 7, 7);
    in_has_flushed = 0;
    drain();
    out_hold = 1;
    alu(1, 2, 32'h60, 32'h0, 8'h08, 0, 5, 7);
    in_valid = 1; in_right_is_memory = 1; in_right_reg = 3; data_valid = 0;
    @(posedge clock);
    @(posedge clock); #2;
    chk("t6_pre_stall", {16'b0, stall_count}, 7);
    reset_n = 0;
    #1;
    chk("t6_addr_en", {31'b0, address_enable}, 0);
    chk("t6_in_hold", {31'b0, in_hold}, 0);
    chk("t6_out_valid", {31'b0, out_valid}, 0);
    chk("t6_stall", {16'b0, stall_count}, 0);
    q.delete();
    in_valid = 0; in_right_is_memory = 0; out_hold = 0;
    @(posedge clock); #1;
    reset_n = 1;
    @(posedge clock); #1;
    mem(2, 3, 32'h70, 32'h10, 7, 32'h110, 1, 32'hEE);
    chk("t6_restart_stall", {16'b0, stall_count}, 1);
    drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule
